// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register-index width, multiply/divide defaults
// and the source-operand match helper used by the hazard and forwarding units.
package hazard_unit_pkg;

  localparam int REG_W          = 5;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  // True when a producer register r feeds a source operand of the ID instruction; $0 never matches.
  function automatic logic reg_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-controller signal bundle; the pipeline is the master.
// StallCount/FlushCount exist only when HAZARD_STATS_EN is defined.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             IF_ID_UsesRt;
  logic             IF_ID_Branch;
  logic             IF_ID_Mul;
  logic             IF_ID_Div;
  logic             IF_ID_ReadsHiLo;
  logic             BranchTaken;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] ID_EX_Rd;
  logic             EX_MEM_MemRead;
  logic [REG_W-1:0] EX_MEM_Rd;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             MulDivStart;
  logic             MulDivBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0]      StallCount;
  logic [31:0]      FlushCount;
`endif

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, IF_ID_Mul, IF_ID_Div,
           IF_ID_ReadsHiLo, BranchTaken, ID_EX_MemRead, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivStart, MulDivBusy
`ifdef HAZARD_STATS_EN
    , input StallCount, FlushCount
`endif
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, IF_ID_Mul, IF_ID_Div,
           IF_ID_ReadsHiLo, BranchTaken, ID_EX_MemRead, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivStart, MulDivBusy
`ifdef HAZARD_STATS_EN
    , output StallCount, FlushCount
`endif
  );

endinterface

// File: rtl/hazard_unit_muldiv_timer.sv
// Busy timer for the HI/LO multiply/divide unit: loads on start, counts down to idle.
// busy_o is registered; it rises the cycle after a start and lasts MUL_CYCLES or DIV_CYCLES.
module muldiv_timer
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_mul_i,
  input  logic start_div_i,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Divide wins if both starts are raised together.
  always_comb begin
    cnt_d = cnt_q;
    if (start_div_i) begin
      cnt_d = CNT_W'(DIV_CYCLES);
    end else if (start_mul_i) begin
      cnt_d = CNT_W'(MUL_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: load-use / branch-after-load / HI/LO stalls, taken-branch flush, mul/div start.
// Zero-latency combinational outputs; HAZARD_STATS_EN adds StallCount/FlushCount counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  logic busy;
  logic load_use;
  logic branch_load;
  logic hilo_conflict;
  logic md_req;
  logic stall;
  logic flush;
  logic start;

  assign md_req        = hz.IF_ID_Mul | hz.IF_ID_Div;
  assign load_use      = hz.ID_EX_MemRead &
                         reg_match(hz.ID_EX_Rd, hz.IF_ID_Rs, hz.IF_ID_Rt, hz.IF_ID_UsesRt);
  assign branch_load   = hz.IF_ID_Branch & hz.EX_MEM_MemRead &
                         reg_match(hz.EX_MEM_Rd, hz.IF_ID_Rs, hz.IF_ID_Rt, hz.IF_ID_UsesRt);
  assign hilo_conflict = busy & (hz.IF_ID_ReadsHiLo | md_req);

  // Reset holds the front end open and suppresses any start.
  assign stall = ~rst & (load_use | branch_load | hilo_conflict);
  assign flush = ~rst & hz.BranchTaken & ~stall;
  assign start = ~rst & md_req & ~stall & ~busy;

  assign hz.PCWrite      = ~stall;
  assign hz.IF_ID_Write  = ~stall;
  assign hz.ID_EX_Bubble = stall;
  assign hz.IF_ID_Flush  = flush;
  assign hz.MulDivStart  = start;
  assign hz.MulDivBusy   = busy;

  muldiv_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start_mul_i (start & ~hz.IF_ID_Div),
    .start_div_i (start & hz.IF_ID_Div),
    .busy_o      (busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, stall};
    flush_cnt_d = flush_cnt_q + {31'b0, flush};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a cycle-number based reference model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int MUL = 4;
  localparam int DIV = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if hz();

  hazard_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int checks = 0;
  int errors = 0;

  // Model state: the unit is busy while the cycle index is below busy_end.
  int cyc = 0;
  int busy_end = 0;
  int m_stall = 0;
  int m_flush = 0;
  int mfhi_stalls = 0;
  logic [5:0] e_upd;

  function automatic bit mt(input logic [4:0] r);
    return (r != 0) && ((r == hz.IF_ID_Rs) || (hz.IF_ID_UsesRt && (r == hz.IF_ID_Rt)));
  endfunction

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MulDivStart, MulDivBusy}
  function automatic logic [5:0] expected();
    bit busy, st, fl, go;
    busy = (cyc < busy_end);
    if (rst) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, busy};
    st = (hz.ID_EX_MemRead && mt(hz.ID_EX_Rd)) ||
         (hz.IF_ID_Branch && hz.EX_MEM_MemRead && mt(hz.EX_MEM_Rd)) ||
         (busy && (hz.IF_ID_ReadsHiLo || hz.IF_ID_Mul || hz.IF_ID_Div));
    fl = hz.BranchTaken && !st;
    go = (hz.IF_ID_Mul || hz.IF_ID_Div) && !st;
    return {!st, !st, fl, st, go, busy};
  endfunction

  function automatic logic [5:0] outs();
    return {hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble, hz.MulDivStart, hz.MulDivBusy};
  endfunction

  always @(posedge clk) begin
    e_upd = expected();
    if (rst) begin
      busy_end = 0;
      m_stall  = 0;
      m_flush  = 0;
    end else begin
      if (e_upd[1]) busy_end = cyc + (hz.IF_ID_Div ? DIV : MUL) + 1;
      if (e_upd[2]) m_stall++;
      if (e_upd[3]) m_flush++;
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    hz.IF_ID_Rs = 0; hz.IF_ID_Rt = 0; hz.IF_ID_UsesRt = 0; hz.IF_ID_Branch = 0;
    hz.IF_ID_Mul = 0; hz.IF_ID_Div = 0; hz.IF_ID_ReadsHiLo = 0; hz.BranchTaken = 0;
    hz.ID_EX_MemRead = 0; hz.ID_EX_Rd = 0; hz.EX_MEM_MemRead = 0; hz.EX_MEM_Rd = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    hz.ID_EX_MemRead = 1; hz.ID_EX_Rd = 3; hz.IF_ID_Rs = 3; hz.BranchTaken = 1; hz.IF_ID_Div = 1;
    @(negedge clk);
    checks++;
    if (outs() [5:1] !== 5'b11000) begin
      errors++; $display("FAIL reset_first got=%b exp=%b", outs() [5:1], 5'b11000);
    end
    next();
    @(negedge clk);
    checks++;
    if (outs() !== 6'b110000 || outs() !== expected()) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", outs(), 6'b110000);
    end
    next();
    rst = 0;
    set_idle();
  endtask

  task automatic test_load_use();
    hz.ID_EX_MemRead = 1; hz.ID_EX_Rd = 5; hz.IF_ID_Rs = 5; hz.IF_ID_Rt = 7; hz.IF_ID_UsesRt = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 6'b000100 || outs() !== expected()) begin
      errors++; $display("FAIL load_use_stall got=%b exp=%b", outs(), 6'b000100);
    end
    next();
    hz.ID_EX_MemRead = 0; hz.EX_MEM_MemRead = 1; hz.EX_MEM_Rd = 5;
    @(negedge clk);
    checks++;
    if (outs() !== 6'b110000 || outs() !== expected()) begin
      errors++; $display("FAIL load_use_release got=%b exp=%b", outs(), 6'b110000);
    end
    next();
    set_idle();
  endtask

  task automatic test_branch_load();
    logic [5:0] want [3] = '{6'b000100, 6'b000100, 6'b111000};
    hz.ID_EX_MemRead = 1; hz.ID_EX_Rd = 5; hz.IF_ID_Rs = 5; hz.IF_ID_Rt = 0;
    hz.IF_ID_UsesRt = 1; hz.IF_ID_Branch = 1; hz.BranchTaken = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        hz.ID_EX_MemRead = 0; hz.EX_MEM_MemRead = 1; hz.EX_MEM_Rd = 5;
      end
      if (i == 2) hz.EX_MEM_MemRead = 0;
      @(negedge clk);
      checks++;
      if (outs() !== want[i] || outs() !== expected()) begin
        errors++; $display("FAIL branch_load cycle=%0d got=%b exp=%b", i, outs(), want[i]);
      end
      next();
    end
    set_idle();
  endtask

  task automatic test_div_mfhi();
    int busy_cycles = 0;
    bit released = 0;
    hz.IF_ID_Div = 1;
    @(negedge clk);
    checks++;
    if (outs() !== 6'b110010) begin
      errors++; $display("FAIL div_start got=%b exp=%b", outs(), 6'b110010);
    end
    next();
    hz.IF_ID_Div = 0; hz.IF_ID_ReadsHiLo = 1;
    mfhi_stalls = 0;
    for (int i = 0; i < DIV + 8 && !released; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== expected()) begin
        errors++; $display("FAIL div_mfhi cycle=%0d got=%b exp=%b", i, outs(), expected());
      end
      if (hz.MulDivBusy) busy_cycles++;
      if (hz.ID_EX_Bubble) mfhi_stalls++;
      else released = 1;
      next();
    end
    checks++;
    if (!released || busy_cycles != DIV || mfhi_stalls != DIV) begin
      errors++; $display("FAIL div_busy_len busy=%0d stalls=%0d released=%0d exp=%0d", busy_cycles, mfhi_stalls, released, DIV);
    end
    set_idle();
  endtask

  task automatic test_stats();
`ifdef HAZARD_STATS_EN
    checks++;
    if (hz.StallCount !== 32'(m_stall) || hz.StallCount !== 32'(3 + mfhi_stalls) || hz.FlushCount !== 32'd1) begin
      errors++; $display("FAIL stats_count stall=%0d flush=%0d exp_stall=%0d exp_flush=1", hz.StallCount, hz.FlushCount, 3 + mfhi_stalls);
    end
    rst = 1;
    next();
    rst = 0;
    @(negedge clk);
    checks++;
    if (hz.StallCount !== 32'd0 || hz.FlushCount !== 32'd0) begin
      errors++; $display("FAIL stats_reset stall=%0d flush=%0d exp=0", hz.StallCount, hz.FlushCount);
    end
    next();
`endif
  endtask

  task automatic test_mul_mul();
    int starts = 0, stalls = 0;
    int first = 0, second = 0;
    for (int i = 0; i < 12; i++) begin
      hz.IF_ID_Mul = (starts < 2);
      @(negedge clk);
      checks++;
      if (outs() !== expected()) begin
        errors++; $display("FAIL mul_mul cycle=%0d got=%b exp=%b", i, outs(), expected());
      end
      if (hz.ID_EX_Bubble) stalls++;
      if (hz.MulDivStart) begin
        if (starts == 0) first = i; else second = i;
        starts++;
      end
      next();
    end
    checks++;
    if (starts != 2 || second - first != MUL + 1 || stalls != MUL) begin
      errors++; $display("FAIL mul_mul_spacing starts=%0d gap=%0d stalls=%0d exp=2/%0d/%0d", starts, second - first, stalls, MUL + 1, MUL);
    end
    set_idle();
  endtask

  task automatic test_reset_busy();
    hz.IF_ID_Div = 1;
    next();
    hz.IF_ID_Div = 0;
    for (int i = 1; i < 10; i++) next();
    rst = 1;
    hz.IF_ID_ReadsHiLo = 1; hz.ID_EX_MemRead = 1; hz.ID_EX_Rd = 2; hz.IF_ID_Rs = 2;
    @(negedge clk);
    checks++;
    if (outs() !== 6'b110001 || outs() !== expected()) begin
      errors++; $display("FAIL reset_busy_during got=%b exp=%b", outs(), 6'b110001);
    end
    next();
    rst = 0;
    hz.ID_EX_MemRead = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 6'b110000 || outs() !== expected()) begin
        errors++; $display("FAIL reset_busy_after cycle=%0d got=%b exp=%b", i, outs(), 6'b110000);
      end
      next();
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      hz.IF_ID_Rs        = 5'($urandom_range(0, 3));
      hz.IF_ID_Rt        = 5'($urandom_range(0, 3));
      hz.IF_ID_UsesRt    = 1'($urandom);
      hz.IF_ID_Branch    = 1'($urandom);
      hz.IF_ID_Mul       = ($urandom_range(0, 7) == 0);
      hz.IF_ID_Div       = ($urandom_range(0, 15) == 0);
      hz.IF_ID_ReadsHiLo = ($urandom_range(0, 3) == 0);
      hz.BranchTaken     = 1'($urandom);
      hz.ID_EX_MemRead   = 1'($urandom);
      hz.ID_EX_Rd        = 5'($urandom_range(0, 3));
      hz.EX_MEM_MemRead  = 1'($urandom);
      hz.EX_MEM_Rd       = 5'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (outs() !== expected()) begin
        errors++; $display("FAIL random cycle=%0d got=%b exp=%b", i, outs(), expected());
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (hz.StallCount !== 32'(m_stall) || hz.FlushCount !== 32'(m_flush)) begin
        errors++; $display("FAIL random_stats cycle=%0d stall=%0d flush=%0d exp=%0d/%0d", i, hz.StallCount, hz.FlushCount, m_stall, m_flush);
      end
`endif
      next();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_div_mfhi();
    test_stats();
    test_mul_mul();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
